bus_cycle_ctrl: RTL and testbench
=================================

// Module: bus_cycle_ctrl
// PURPOSE
//  i8080 machine-cycle timing generator, directly upstream of the data bus buffer.
//  Sequences T1/T2/TW/T3 per requested cycle type; drives SYNC + status word, DBIN, WR_n.
//  Also drives the buffer enables (out_wenable/out_enable/in_enable) and the address-bus latch.
//  Accepts one cycle request at a time from the instruction control unit.
// PARAMETERS
//  XLEN  8   data/status width
//  AW    16  address width
// PORTS
//  clk          in   1     system clock, all state on rising edge
//  rst          in   1     asynchronous, active-low reset
//  cycle_req    in   1     start a machine cycle (sampled in IDLE and T3 only)
//  cycle_type   in   4     0 FETCH,1 MEMRD,2 MEMWR,3 STKRD,4 STKWR,5 IN,6 OUT,7 INTA,8 HALT,9 INTAH
//  addr_in      in   AW    cycle address, captured on accept
//  ready        in   1     external READY, sampled in T2/TW
//  int_req      in   1     interrupt request, sampled only in HALTED
//  busy         out  1     1 in any state except IDLE and T3
//  cycle_done   out  1     1-clock pulse in final state of a cycle (T3, or HALTED exit)
//  illegal      out  1     1-clock pulse: request with cycle_type 10..15
//  addr_out     out  AW    latched address
//  addr_oe      out  1     address bus drive, T1..T3 and HALTED
//  sync         out  1     status strobe, T1 only
//  status       out  XLEN  status word of current cycle (0 in IDLE)
//  dbin         out  1     read strobe, read types in T2/TW/T3
//  wr_n         out  1     write strobe, active low, write types in T3 only
//  wait_o       out  1     1 in TW and HALTED
//  out_wenable  out  1     buffer captures write data, write types in T1
//  out_enable   out  1     buffer drives write data, write types in T2/TW/T3
//  in_enable    out  1     buffer passes pins to bus, read types in T3
//  halted       out  1     1 in HALTED
// BEHAVIOUR
//  States: IDLE, T1, T2, TW, T3, HALTED. Registered state + latched type/addr; outputs decoded from them.
//  Reset (rst=0, async): state IDLE, addr_out=0, status=0. All strobes 0 except wr_n=1; takes effect mid-cycle immediately.
//  IDLE: cycle_req with legal type -> T1 next clock; latch type and addr_in.
//   Illegal type -> illegal pulse, stay IDLE.
//  T1: sync=1; status driven. Unconditional -> T2.
//  T2: if HALT/INTAH type -> HALTED. Else ready=1 -> T3; ready=0 -> TW.
//  TW: stay while ready=0; ready=1 -> T3. Strobes as T2.
//  T3: cycle_done=1.
//   cycle_req with legal type -> T1 (back-to-back, no IDLE gap; new type/addr latched).
//   Illegal type -> illegal pulse + IDLE. No cycle_req -> IDLE.
//  HALTED: dbin=0; wait_o=1. int_req=1 -> cycle_done pulse, IDLE.
//   int_req checked only here, so HALTED lasts >=1 clock.
//  Read types: FETCH, MEMRD, STKRD, IN, INTA, HALT, INTAH (dbin only for non-halt types).
//  Write types: MEMWR, STKWR, OUT.
//  Status (D7 MEMR,D6 INP,D5 M1,D4 OUT,D3 HLTA,D2 STACK,D1 WO_n,D0 INTA):
//   FETCH A2, MEMRD 82, MEMWR 00, STKRD 86, STKWR 04, IN 42, OUT 10.
//   INTA 23, HALT 8A, INTAH 2B.
//  cycle_req outside IDLE/T3 ignored (caller must honour busy).
//  ready ignored outside T2/TW.
//  Minimum cycle 3 clocks (T1,T2,T3). Request-to-sync latency 1 clock.
//  addr_out stable from T1 through T3/HALTED; retained in IDLE.
// TESTING
//  1. FETCH addr 0x1234, ready=1 -> T1 sync=1 status=A2 addr_out=1234; T2 dbin=1; T3 in_enable=1, cycle_done=1; 3 clocks.
//  2. MEMWR addr 0x2000, ready=0 two clocks -> T1 out_wenable; T2,TW,TW out_enable=1, wait_o=1 in TW; T3 wr_n=0; 5 clocks.
//  3. HALT, int_req after 4 clocks -> status 8A, halted=1 from 3rd clock, cycle_done on exit, then IDLE.
//  4. IN then OUT requested in T3 -> status 42 then 10, second T1 immediately after first T3, no IDLE.
//  5. cycle_type 0xC -> illegal pulse 1 clock, busy stays 0, no sync.
//  6. rst=0 during T3 of STKWR -> wr_n=1, out_enable=0, status=0 without clock; after release, IDLE.

Source files
------------

// File: rtl/bus_cycle_ctrl.sv
// i8080 machine-cycle timing generator: T1/T2/TW/T3/HALTED sequencing,
// status word, bus strobes and data-buffer enables.
module bus_cycle_ctrl #(
    parameter int XLEN = 8,
    parameter int AW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cycle_req,
    input  logic [3:0]      cycle_type,
    input  logic [AW-1:0]   addr_in,
    input  logic            ready,
    input  logic            int_req,
    output logic            busy,
    output logic            cycle_done,
    output logic            illegal,
    output logic [AW-1:0]   addr_out,
    output logic            addr_oe,
    output logic            sync,
    output logic [XLEN-1:0] status,
    output logic            dbin,
    output logic            wr_n,
    output logic            wait_o,
    output logic            out_wenable,
    output logic            out_enable,
    output logic            in_enable,
    output logic            halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_T1     = 3'd1;
    localparam logic [2:0] S_T2     = 3'd2;
    localparam logic [2:0] S_TW     = 3'd3;
    localparam logic [2:0] S_T3     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [3:0]    r_type;
    logic [AW-1:0] r_addr;
    logic          w_legal;
    logic          w_open;
    logic          w_accept;
    logic          w_read;
    logic          w_write;
    logic          w_halt;
    logic          w_t2w;
    logic          w_t3;
    logic [7:0]    w_stat;

    assign w_legal  = (cycle_type <= 4'd9);
    assign w_open   = (r_state == S_IDLE) || (r_state == S_T3);
    assign w_accept = w_open && cycle_req && w_legal;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_T1;
            S_T1:     w_next = S_T2;
            S_T2: begin
                if (w_halt)     w_next = S_HALTED;
                else if (ready) w_next = S_T3;
                else            w_next = S_TW;
            end
            S_TW:     if (ready) w_next = S_T3;
            S_T3:     w_next = w_accept ? S_T1 : S_IDLE;
            S_HALTED: if (int_req) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_type  <= 4'd0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_type <= cycle_type;
                r_addr <= addr_in;
            end
        end
    end

    // Status bits: D7 MEMR D6 INP D5 M1 D4 OUT D3 HLTA D2 STACK D1 WO_n D0 INTA
    always_comb begin
        w_stat  = 8'h00;
        w_read  = 1'b0;
        w_write = 1'b0;
        w_halt  = 1'b0;
        case (r_type)
            4'd0: begin w_stat = 8'hA2; w_read = 1'b1; end
            4'd1: begin w_stat = 8'h82; w_read = 1'b1; end
            4'd2: begin w_stat = 8'h00; w_write = 1'b1; end
            4'd3: begin w_stat = 8'h86; w_read = 1'b1; end
            4'd4: begin w_stat = 8'h04; w_write = 1'b1; end
            4'd5: begin w_stat = 8'h42; w_read = 1'b1; end
            4'd6: begin w_stat = 8'h10; w_write = 1'b1; end
            4'd7: begin w_stat = 8'h23; w_read = 1'b1; end
            4'd8: begin w_stat = 8'h8A; w_read = 1'b1; w_halt = 1'b1; end
            4'd9: begin w_stat = 8'h2B; w_read = 1'b1; w_halt = 1'b1; end
            default: w_stat = 8'h00;
        endcase
    end

    assign w_t2w = (r_state == S_T2) || (r_state == S_TW);
    assign w_t3  = (r_state == S_T3);

    assign busy        = !w_open;
    assign cycle_done  = w_t3 || ((r_state == S_HALTED) && int_req);
    assign illegal     = w_open && cycle_req && !w_legal;
    assign addr_out    = r_addr;
    assign addr_oe     = (r_state != S_IDLE);
    assign sync        = (r_state == S_T1);
    assign status      = (r_state == S_IDLE) ? '0 : XLEN'(w_stat);
    assign dbin        = w_read && !w_halt && (w_t2w || w_t3);
    assign wr_n        = !(w_write && w_t3);
    assign wait_o      = (r_state == S_TW) || (r_state == S_HALTED);
    assign out_wenable = w_write && (r_state == S_T1);
    assign out_enable  = w_write && (w_t2w || w_t3);
    assign in_enable   = w_read && w_t3;
    assign halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed-vector bench for bus_cycle_ctrl; inputs change and outputs are
// checked just after the falling edge.
module tb_bus_cycle_ctrl;

    logic        clk;
    logic        rst;
    logic        cycle_req;
    logic [3:0]  cycle_type;
    logic [15:0] addr_in;
    logic        ready;
    logic        int_req;
    logic        busy;
    logic        cycle_done;
    logic        illegal;
    logic [15:0] addr_out;
    logic        addr_oe;
    logic        sync;
    logic [7:0]  status;
    logic        dbin;
    logic        wr_n;
    logic        wait_o;
    logic        out_wenable;
    logic        out_enable;
    logic        in_enable;
    logic        halted;

    int n_chk;
    int n_err;

    bus_cycle_ctrl #(.XLEN(8), .AW(16)) dut (
        .clk(clk), .rst(rst), .cycle_req(cycle_req),
        .cycle_type(cycle_type), .addr_in(addr_in), .ready(ready),
        .int_req(int_req), .busy(busy), .cycle_done(cycle_done),
        .illegal(illegal), .addr_out(addr_out), .addr_oe(addr_oe),
        .sync(sync), .status(status), .dbin(dbin), .wr_n(wr_n),
        .wait_o(wait_o), .out_wenable(out_wenable),
        .out_enable(out_enable), .in_enable(in_enable), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b0;
        cycle_req = 1'b0;
        cycle_type = 4'd0;
        addr_in = 16'h0;
        ready = 1'b1;
        int_req = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_status", status, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_wr_n", wr_n, 1);
        chk("rst_oe", addr_oe, 0);
        nxt();
        nxt();
        rst = 1'b1;

        // 1: FETCH 0x1234, ready=1
        cycle_req = 1'b1; cycle_type = 4'd0; addr_in = 16'h1234;
        #1 chk("f_idle_busy", busy, 0);
        nxt(); cycle_req = 1'b0; addr_in = 16'hFFFF;
        #1 chk("f_t1_sync", sync, 1);
        chk("f_t1_status", status, 8'hA2);
        chk("f_t1_addr", addr_out, 16'h1234);
        chk("f_t1_busy", busy, 1);
        nxt();
        #1 chk("f_t2_dbin", dbin, 1);
        chk("f_t2_sync", sync, 0);
        nxt();
        #1 chk("f_t3_inen", in_enable, 1);
        chk("f_t3_done", cycle_done, 1);
        chk("f_t3_busy", busy, 0);
        nxt();
        #1 chk("f_idle_status", status, 0);
        chk("f_idle_addr", addr_out, 16'h1234);
        chk("f_idle_done", cycle_done, 0);

        // 2: MEMWR 0x2000, two wait states
        cycle_req = 1'b1; cycle_type = 4'd2; addr_in = 16'h2000;
        ready = 1'b0;
        nxt(); cycle_req = 1'b0;
        #1 chk("w_t1_owen", out_wenable, 1);
        chk("w_t1_status", status, 8'h00);
        chk("w_t1_oen", out_enable, 0);
        nxt();
        #1 chk("w_t2_oen", out_enable, 1);
        chk("w_t2_wait", wait_o, 0);
        chk("w_t2_wr_n", wr_n, 1);
        nxt();
        #1 chk("w_tw1_wait", wait_o, 1);
        chk("w_tw1_oen", out_enable, 1);
        nxt(); ready = 1'b1;
        #1 chk("w_tw2_wait", wait_o, 1);
        chk("w_tw2_dbin", dbin, 0);
        nxt();
        #1 chk("w_t3_wr_n", wr_n, 0);
        chk("w_t3_done", cycle_done, 1);
        chk("w_t3_wait", wait_o, 0);
        nxt();

        // 3: HALT, int_req on 4th clock
        cycle_req = 1'b1; cycle_type = 4'd8; addr_in = 16'h0042;
        nxt(); cycle_req = 1'b0;
        #1 chk("h_t1_status", status, 8'h8A);
        nxt();
        #1 chk("h_t2_dbin", dbin, 0);
        chk("h_t2_halted", halted, 0);
        nxt();
        #1 chk("h_hlt_halted", halted, 1);
        chk("h_hlt_wait", wait_o, 1);
        chk("h_hlt_done", cycle_done, 0);
        chk("h_hlt_oe", addr_oe, 1);
        nxt(); int_req = 1'b1;
        #1 chk("h_hlt2_halted", halted, 1);
        chk("h_exit_done", cycle_done, 1);
        nxt(); int_req = 1'b0;
        #1 chk("h_idle_halted", halted, 0);
        chk("h_idle_busy", busy, 0);
        chk("h_idle_status", status, 0);

        // 4: IN then OUT back-to-back
        cycle_req = 1'b1; cycle_type = 4'd5; addr_in = 16'h00AB;
        nxt(); cycle_req = 1'b0;
        #1 chk("io_t1_status", status, 8'h42);
        nxt();
        #1 chk("io_t2_dbin", dbin, 1);
        nxt();
        cycle_req = 1'b1; cycle_type = 4'd6; addr_in = 16'h00CD;
        #1 chk("io_t3_done", cycle_done, 1);
        chk("io_t3_inen", in_enable, 1);
        nxt(); cycle_req = 1'b0;
        #1 chk("io_t1b_sync", sync, 1);
        chk("io_t1b_status", status, 8'h10);
        chk("io_t1b_addr", addr_out, 16'h00CD);
        nxt();
        nxt();
        #1 chk("io_t3b_wr_n", wr_n, 0);
        nxt();
        #1 chk("io_idle_oe", addr_oe, 0);

        // 5: illegal type 0xC
        cycle_req = 1'b1; cycle_type = 4'hC; addr_in = 16'h5555;
        #1 chk("il_pulse", illegal, 1);
        chk("il_busy", busy, 0);
        nxt(); cycle_req = 1'b0;
        #1 chk("il_clear", illegal, 0);
        chk("il_sync", sync, 0);
        chk("il_busy2", busy, 0);
        chk("il_addr", addr_out, 16'h00CD);

        // 6: async reset during T3 of STKWR
        cycle_req = 1'b1; cycle_type = 4'd4; addr_in = 16'h3456;
        nxt(); cycle_req = 1'b0;
        #1 chk("sr_t1_status", status, 8'h04);
        nxt();
        nxt();
        #1 chk("sr_t3_wr_n", wr_n, 0);
        chk("sr_t3_oen", out_enable, 1);
        #1 rst = 1'b0;
        #1 chk("sr_rst_wr_n", wr_n, 1);
        chk("sr_rst_oen", out_enable, 0);
        chk("sr_rst_status", status, 0);
        chk("sr_rst_addr", addr_out, 0);
        nxt(); rst = 1'b1;
        nxt();
        #1 chk("sr_idle_busy", busy, 0);
        chk("sr_idle_sync", sync, 0);
        chk("sr_idle_oe", addr_oe, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
